// File: rtl/key_entry_tx.sv
// -----------------------------------------------------------------------------
// key_entry_tx
//   Keypad front-end for the lock core. The ten digit keys and the
//   sure/change/open buttons are synchronised and debounced as one vector.
//   Each accepted press is queued in a 4-deep FIFO. It is then replayed as a
//   one-hot din word with a single-cycle load strobe, or as a single-cycle
//   sure/change/open pulse. Order is preserved.
//
//   Optional feature (macro AUTO_SURE_EN): when a load strobe brings digit_cnt
//   up to DIGITS, one extra sure transfer is inserted right after that
//   transfer. It takes priority over the FIFO head.
//
// Ports
//   clk         system clock
//   rst         synchronous active-low reset
//   key_raw     raw digit buttons, bit i = digit i
//   sure_raw    raw confirm button
//   change_raw  raw change-password button
//   open_raw    raw open button
//   din         one-hot digit to the lock core (0 for commands)
//   load        digit strobe, 1 cycle
//   sure        confirm strobe, 1 cycle
//   change      change strobe, 1 cycle
//   open        open strobe, 1 cycle
//   busy        FIFO non-empty or transfer in progress
//   err         1-cycle pulse on a multi-key press or a FIFO overflow
//   digit_cnt   digits sent since the last command, saturating at 15
//   fifo_cnt    FIFO occupancy, 0..4
// -----------------------------------------------------------------------------
module key_entry_tx #(
  parameter int DEBOUNCE_CYCLES = 20,
  parameter int GAP_CYCLES      = 2,
  parameter int DIGITS          = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] key_raw,
  input  logic       sure_raw,
  input  logic       change_raw,
  input  logic       open_raw,
  output logic [9:0] din,
  output logic       load,
  output logic       sure,
  output logic       change,
  output logic       open,
  output logic       busy,
  output logic       err,
  output logic [3:0] digit_cnt,
  output logic [2:0] fifo_cnt
);

`ifdef AUTO_SURE_EN
  localparam bit AUTO_SURE = 1'b1;
`else
  localparam bit AUTO_SURE = 1'b0;
`endif

  localparam int DCW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int GW  = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  localparam logic [3:0] CODE_SURE = 4'd10;

  typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_e;

  // ---------------------------------------------------------------------------
  // Input conditioning
  // ---------------------------------------------------------------------------
  logic [12:0]    sync1_q, sync2_q, cand_q, acc_q;
  logic [DCW-1:0] deb_cnt_q;
  logic           deb_stable, press, press_onehot;
  logic [3:0]     press_code;

  assign deb_stable = (deb_cnt_q == DCW'(DEBOUNCE_CYCLES));
  // A press happens only on the cycle the accepted vector leaves all-zero.
  assign press        = deb_stable && (acc_q == '0) && (cand_q != '0);
  assign press_onehot = ((cand_q & (cand_q - 13'd1)) == '0);

  // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    press_code = '0;
    for (int i = 0; i < 13; i++) begin
      if (cand_q[i]) press_code = 4'(i);
    end
  end

  // NOTE: sequential state uses <= so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      cand_q    <= '0;
      deb_cnt_q <= '0;
      acc_q     <= '0;
    end else begin
      sync1_q <= {open_raw, change_raw, sure_raw, key_raw};
      sync2_q <= sync1_q;
      if (sync2_q != cand_q) begin
        cand_q    <= sync2_q;
        deb_cnt_q <= '0;
      end else if (!deb_stable) begin
        deb_cnt_q <= deb_cnt_q + DCW'(1);
      end
      if (deb_stable) acc_q <= cand_q;
    end
  end

  // ---------------------------------------------------------------------------
  // FIFO and transfer control
  // ---------------------------------------------------------------------------
  logic [3:0]    mem_q [4];
  logic [1:0]    wr_ptr_q, rd_ptr_q;
  logic [2:0]    fifo_cnt_q, fifo_cnt_d;
  state_e        state_q, state_d;
  logic [3:0]    code_q;
  logic [GW-1:0] gap_q;
  logic          auto_q, err_q, err_d;
  logic [3:0]    digit_cnt_q, digit_cnt_d;
  logic          fifo_empty, fifo_full, push_req, push_ok, pop;
  logic          gap_last, xfer_slot, start_xfer, auto_set;

  assign fifo_empty = (fifo_cnt_q == 3'd0);
  assign fifo_full  = (fifo_cnt_q == 3'd4);
  assign gap_last   = (gap_q == GW'(GAP_CYCLES - 1));

  // A new transfer may start from IDLE or straight out of the last HOLD cycle.
  // Starting from HOLD keeps back-to-back transfers at 2 + GAP_CYCLES cycles.
  assign xfer_slot  = (state_q == IDLE) || ((state_q == HOLD) && gap_last);
  assign start_xfer = xfer_slot && (auto_q || !fifo_empty);
  assign pop        = start_xfer && !auto_q;

  assign push_req = press && press_onehot;
  // A full FIFO still takes the write if the head leaves in the same cycle.
  assign push_ok  = push_req && (!fifo_full || pop);
  assign err_d    = (press && !press_onehot) || (push_req && !push_ok);

  assign auto_set = AUTO_SURE && load && (digit_cnt_q == 4'(DIGITS - 1));

  always_comb begin
    fifo_cnt_d = fifo_cnt_q;
    if (push_ok && !pop)      fifo_cnt_d = fifo_cnt_q + 3'd1;
    else if (!push_ok && pop) fifo_cnt_d = fifo_cnt_q - 3'd1;
  end

  always_comb begin
    digit_cnt_d = digit_cnt_q;
    if (load && (digit_cnt_q != 4'd15)) digit_cnt_d = digit_cnt_q + 4'd1;
    else if (sure || change || open)    digit_cnt_d = 4'd0;
  end

  // NOTE: the FIFO storage has no reset; the pointers and count define which entries are valid.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= press_code;
  end

  // FSM state register plus the datapath it steers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      fifo_cnt_q  <= '0;
      code_q      <= '0;
      gap_q       <= '0;
      auto_q      <= 1'b0;
      err_q       <= 1'b0;
      digit_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      fifo_cnt_q  <= fifo_cnt_d;
      err_q       <= err_d;
      digit_cnt_q <= digit_cnt_d;
      if (push_ok) wr_ptr_q <= wr_ptr_q + 2'd1;
      if (pop)     rd_ptr_q <= rd_ptr_q + 2'd1;
      if (start_xfer) code_q <= auto_q ? CODE_SURE : mem_q[rd_ptr_q];
      if (state_q == STROBE)    gap_q <= '0;
      else if (state_q == HOLD) gap_q <= gap_q + GW'(1);
      if (auto_set)                  auto_q <= 1'b1;
      else if (start_xfer && auto_q) auto_q <= 1'b0;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start_xfer) state_d = SETUP;
      SETUP:   state_d = STROBE;
      STROBE:  state_d = HOLD;
      HOLD:    if (gap_last) state_d = start_xfer ? SETUP : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    din    = '0;
    load   = 1'b0;
    sure   = 1'b0;
    change = 1'b0;
    open   = 1'b0;
    if ((state_q != IDLE) && (code_q < 4'd10)) din = 10'(1) << code_q;
    if (state_q == STROBE) begin
      unique case (code_q)
        4'd10:   sure   = 1'b1;
        4'd11:   change = 1'b1;
        4'd12:   open   = 1'b1;
        default: load   = 1'b1;
      endcase
    end
  end

  assign busy      = !fifo_empty || (state_q != IDLE);
  assign err       = err_q;
  assign digit_cnt = digit_cnt_q;
  assign fifo_cnt  = fifo_cnt_q;

endmodule

// File: tb/tb_key_entry_tx.sv
// -----------------------------------------------------------------------------
// tb_key_entry_tx
//   Scoreboard bench for key_entry_tx. Stimulus tasks push the expected strobe
//   (kind, din, digit_cnt afterwards, spacing to the previous strobe) into a
//   queue. An independent monitor pops and compares whenever a strobe appears.
//   GAP_CYCLES is made long so that presses queue up faster than they drain.
//   This exercises the FIFO-full and overflow paths with fixed, hand-known
//   ordering.
// -----------------------------------------------------------------------------
module tb_key_entry_tx;

  localparam int DEB   = 4;
  localparam int GAP   = 120;
  localparam int XFER  = 2 + GAP;
  localparam int NDIG  = 4;
  localparam int PHOLD = 7;   // cycles a queued press is held, then released

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [9:0] key_raw = '0;
  logic       sure_raw = 1'b0, change_raw = 1'b0, open_raw = 1'b0;
  logic [9:0] din;
  logic       load, sure, change, open, busy, err;
  logic [3:0] digit_cnt;
  logic [2:0] fifo_cnt;

  key_entry_tx #(
    .DEBOUNCE_CYCLES(DEB),
    .GAP_CYCLES     (GAP),
    .DIGITS         (NDIG)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .key_raw   (key_raw),
    .sure_raw  (sure_raw),
    .change_raw(change_raw),
    .open_raw  (open_raw),
    .din       (din),
    .load      (load),
    .sure      (sure),
    .change    (change),
    .open      (open),
    .busy      (busy),
    .err       (err),
    .digit_cnt (digit_cnt),
    .fifo_cnt  (fifo_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] kind;   // 0 load, 1 sure, 2 change, 3 open
    logic [9:0] din;
    logic [3:0] dcnt;   // digit_cnt expected after the strobe
    int         gap;    // required cycles since the previous strobe, 0 = any
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   m_dcnt = 0;
  int   want_gap = 0;

  // Monitor state
  int         cyc = 0;
  int         last_stb = 0;
  int         err_seen = 0;
  int         fifo_peak = 0;
  bit         dcnt_pend = 0;
  logic [3:0] dcnt_exp;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Monitor
  // ---------------------------------------------------------------------------
  always @(negedge clk) begin
    int   nstb;
    exp_t e;
    logic [1:0] kind;
    cyc++;
    if (dcnt_pend) begin
      check("digit_cnt_after_strobe", 32'(digit_cnt), 32'(dcnt_exp));
      dcnt_pend = 0;
    end
    if (err === 1'b1) err_seen++;
    if (int'(fifo_cnt) > fifo_peak) fifo_peak = int'(fifo_cnt);
    nstb = int'(load) + int'(sure) + int'(change) + int'(open);
    if (nstb > 1) check("single_strobe", 32'(nstb), 32'd1);
    if ((din & (din - 10'd1)) != 10'd0) check("din_onehot_or_zero", 32'(din), 32'd0);
    if (nstb != 0) begin
      kind = load ? 2'd0 : sure ? 2'd1 : change ? 2'd2 : 2'd3;
      if (sb.size() == 0) begin
        check("unexpected_strobe", 32'(kind), 32'hFFFF);
      end else begin
        e = sb.pop_front();
        check("strobe_kind", 32'(kind), 32'(e.kind));
        check("strobe_din", 32'(din), 32'(e.din));
        if (e.gap != 0) check("strobe_spacing", 32'(cyc - last_stb), 32'(e.gap));
        dcnt_exp  = e.dcnt;
        dcnt_pend = 1;
      end
      last_stb = cyc;
    end
  end

  // ---------------------------------------------------------------------------
  // Expectation model
  // ---------------------------------------------------------------------------
  task automatic exp_push(input logic [1:0] kind, input logic [9:0] d, input int dc);
    exp_t e;
    e.kind = kind; e.din = d; e.dcnt = 4'(dc); e.gap = want_gap;
    sb.push_back(e);
    want_gap = XFER;
  endtask

  task automatic exp_digit(input int d);
    logic [9:0] oh;
    oh = 10'(1) << d;
    m_dcnt = (m_dcnt == 15) ? 15 : m_dcnt + 1;
    exp_push(2'd0, oh, m_dcnt);
`ifdef AUTO_SURE_EN
    if (m_dcnt == NDIG) begin
      m_dcnt = 0;
      exp_push(2'd1, 10'd0, 0);
    end
`endif
  endtask

  task automatic exp_cmd(input logic [1:0] kind);
    m_dcnt = 0;
    exp_push(kind, 10'd0, 0);
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic drive(input logic [12:0] v);
    key_raw    = v[9:0];
    sure_raw   = v[10];
    change_raw = v[11];
    open_raw   = v[12];
  endtask

  task automatic press(input logic [12:0] v, input int hi, input int lo);
    @(negedge clk); drive(v);
    repeat (hi) @(negedge clk);
    drive(13'd0);
    repeat (lo) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    drive(13'd0);
    repeat (3) @(negedge clk);
    check("reset_outputs",
          32'({din, load, sure, change, open, busy, err, digit_cnt, fifo_cnt}), 32'd0);
    rst = 1'b1;
    m_dcnt = 0;
    want_gap = 0;
    fifo_peak = 0;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while ((sb.size() != 0 || busy) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check(name, 32'(n < 2000), 32'd1);
    repeat (3) @(negedge clk);
  endtask

  // ---------------------------------------------------------------------------
  // Directed tests
  // ---------------------------------------------------------------------------
  initial begin
    int e0;
    int n;

    // 1: single key, held 20 cycles
    do_reset();
    e0 = err_seen;
    exp_digit(4);
    press(13'h010, 20, 12);
    drain("t1_drain");
    check("t1_digit_cnt", 32'(digit_cnt), 32'd1);
    check("t1_no_err", 32'(err_seen - e0), 32'd0);

    // 2: key 7 bounces every 2 cycles, then is held
    do_reset();
    exp_digit(7);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk); drive(i % 2 == 0 ? 13'h080 : 13'h000);
      @(negedge clk);
    end
    press(13'h080, 12, 12);
    drain("t2_drain");

    // 3: 7,6,5,4 then sure, queued back to back
    do_reset();
    e0 = err_seen;
    exp_digit(7); exp_digit(6); exp_digit(5); exp_digit(4);
    exp_cmd(2'd1);
    press(13'h080, PHOLD, PHOLD);
    press(13'h040, PHOLD, PHOLD);
    press(13'h020, PHOLD, PHOLD);
    press(13'h010, PHOLD, PHOLD);
    press(13'h400, PHOLD, PHOLD);
    drain("t3_drain");
    check("t3_digit_cnt", 32'(digit_cnt), 32'd0);
    check("t3_no_err", 32'(err_seen - e0), 32'd0);

    // 4: eight digits faster than they drain; 0 pops at once, 1..4 fill, 5..7 drop
    do_reset();
    e0 = err_seen;
    for (int d = 0; d < 5; d++) exp_digit(d);
    for (int d = 0; d < 8; d++) press(13'(1) << d, PHOLD, PHOLD);
    check("t4_fifo_peak", 32'(fifo_peak), 32'd4);
    drain("t4_drain");
    check("t4_overflow_errs", 32'(err_seen - e0), 32'd3);
    e0 = err_seen;
    press(13'h011, 12, 12);
    repeat (5) @(negedge clk);
    check("t4_multikey_err", 32'(err_seen - e0), 32'd1);
    check("t4_multikey_idle", 32'(busy), 32'd0);

    // 5: reset during STROBE of a held digit
    do_reset();
    exp_push(2'd0, 10'h008, 0);
    @(negedge clk); drive(13'h008);
    n = 0;
    while (load !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("t5_load_seen", 32'(n < 200), 32'd1);
    rst = 1'b0;
    @(negedge clk);
    check("t5_reset_outputs",
          32'({din, load, sure, change, open, busy, err, digit_cnt, fifo_cnt}), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    m_dcnt = 0;
    want_gap = 0;
    exp_digit(3);
    repeat (20) @(negedge clk);
    drive(13'd0);
    drain("t5_drain");
    check("t5_digit_cnt", 32'(digit_cnt), 32'd1);

`ifdef AUTO_SURE_EN
    // 6: four digits with no sure button
    do_reset();
    exp_digit(1); exp_digit(2); exp_digit(3); exp_digit(9);
    press(13'h002, PHOLD, PHOLD);
    press(13'h004, PHOLD, PHOLD);
    press(13'h008, PHOLD, PHOLD);
    press(13'h200, PHOLD, PHOLD);
    drain("t6_drain");
    check("t6_digit_cnt", 32'(digit_cnt), 32'd0);
`endif

    check("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
